// File: rtl/stream_result_packer.sv
// Packs narrow result beats, lane 0 first, into wide output words; a short packet gives a zero-padded partial word.
// Latency: output tvalid rises one cycle after the input handshake that completes a word.
// Backpressure: a completed word waits in the assembly register and drops results_TREADY; nothing combinational from tready.
module stream_result_packer #(
    parameter int DATA_WIDTH = 512,
    parameter int IN_WIDTH   = 128
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [IN_WIDTH-1:0]     results_TDATA,
    input  logic                    results_TVALID,
    output logic                    results_TREADY,
    input  logic                    results_TLAST,
    output logic [DATA_WIDTH-1:0]   m_axis_out_tdata,
    output logic                    m_axis_out_tvalid,
    input  logic                    m_axis_out_tready,
    output logic [DATA_WIDTH/8-1:0] m_axis_out_tkeep,
    output logic                    m_axis_out_tlast,
    output logic [31:0]             pkt_count,
    output logic                    idle
);

    localparam int RATIO     = DATA_WIDTH / IN_WIDTH;
    localparam int LANE_KEEP = IN_WIDTH / 8;
    localparam int KEEP_W    = DATA_WIDTH / 8;
    localparam int LW        = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [KEEP_W-1:0]     keep;
        logic                  last;
    } word_t;

    word_t           asm_q;
    word_t           asm_next;
    word_t           out_q;
    logic [LW-1:0]   lane_idx;
    logic            asm_full;
    logic            out_vld;
    logic            in_hs;
    logic            out_hs;
    logic            out_free;
    logic            word_done;

    assign results_TREADY = ap_rst_n && !asm_full;
    assign in_hs          = results_TVALID && results_TREADY;
    assign out_hs         = out_vld && m_axis_out_tready;
    assign out_free       = !out_vld || m_axis_out_tready;
    assign word_done      = in_hs && ((lane_idx == LW'(RATIO - 1)) || results_TLAST);

    // Current assembly contents with the incoming beat merged into its lane.
    always_comb begin
        asm_next      = asm_q;
        asm_next.last = results_TLAST;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_idx == LW'(k)) begin
                asm_next.dat[k*IN_WIDTH +: IN_WIDTH]    = results_TDATA;
                asm_next.keep[k*LANE_KEEP +: LANE_KEEP] = '1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            asm_q     <= '0;
            out_q     <= '0;
            lane_idx  <= '0;
            asm_full  <= 1'b0;
            out_vld   <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (out_hs) begin
                out_vld <= 1'b0;
                if (out_q.last) begin
                    pkt_count <= pkt_count + 32'd1;
                end
            end
            if (asm_full) begin
                // Input is blocked while held, so only the transfer can happen here.
                if (out_free) begin
                    out_q    <= asm_q;
                    out_vld  <= 1'b1;
                    asm_q    <= '0;
                    asm_full <= 1'b0;
                end
            end else if (word_done) begin
                lane_idx <= '0;
                if (out_free) begin
                    out_q   <= asm_next;
                    out_vld <= 1'b1;
                    asm_q   <= '0;
                end else begin
                    asm_q    <= asm_next;
                    asm_full <= 1'b1;
                end
            end else if (in_hs) begin
                asm_q    <= asm_next;
                lane_idx <= lane_idx + LW'(1);
            end
        end
    end

    assign m_axis_out_tdata  = out_q.dat;
    assign m_axis_out_tkeep  = out_q.keep;
    assign m_axis_out_tlast  = out_q.last;
    assign m_axis_out_tvalid = out_vld;
    assign idle              = !asm_full && (lane_idx == '0) && !out_vld;

endmodule

// File: tb/tb_stream_result_packer.sv
// Randomized scoreboard bench for stream_result_packer at default widths (512 out, 128 in).
module tb_stream_result_packer;

    localparam int DW = 512;
    localparam int IW = 128;
    localparam int R  = DW / IW;
    localparam int KW = DW / 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [IW-1:0] results_TDATA = '0;
    logic          results_TVALID = 1'b0;
    logic          results_TREADY;
    logic          results_TLAST = 1'b0;
    logic [DW-1:0] m_axis_out_tdata;
    logic          m_axis_out_tvalid;
    logic          m_axis_out_tready = 1'b1;
    logic [KW-1:0] m_axis_out_tkeep;
    logic          m_axis_out_tlast;
    logic [31:0]   pkt_count;
    logic          idle;

    stream_result_packer #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .results_TDATA(results_TDATA), .results_TVALID(results_TVALID),
        .results_TREADY(results_TREADY), .results_TLAST(results_TLAST),
        .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
        .m_axis_out_tready(m_axis_out_tready), .m_axis_out_tkeep(m_axis_out_tkeep),
        .m_axis_out_tlast(m_axis_out_tlast), .pkt_count(pkt_count), .idle(idle)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collect accepted beats, emit a word per RATIO beats or at TLAST.
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } exp_t;

    logic [IW-1:0] cur[$];
    exp_t          expq[$];
    int            exp_pkts = 0;
    int            in_acc = 0;
    int            out_cnt = 0;
    int            stall_cyc = 0;
    bit            track_stall = 0;

    always @(negedge ap_clk) begin
        if (ap_rst_n && results_TVALID && results_TREADY) begin
            in_acc++;
            cur.push_back(results_TDATA);
            if (cur.size() == R || results_TLAST) begin
                exp_t e;
                e.d = '0;
                e.k = '0;
                for (int i = 0; i < cur.size(); i++) begin
                    e.d[i*IW +: IW] = cur[i];
                    for (int b = 0; b < IW/8; b++) e.k[i*(IW/8) + b] = 1'b1;
                end
                e.l = results_TLAST;
                if (e.l) exp_pkts++;
                expq.push_back(e);
                cur.delete();
            end
        end
        if (ap_rst_n && track_stall && results_TVALID && !results_TREADY) stall_cyc++;
    end

    // Output monitor: pops expected words on each handshake and checks hold stability.
    bit            prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic [KW-1:0] prev_k;
    logic          prev_l;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_tvalid", m_axis_out_tvalid, 1);
                check("hold_tdata", m_axis_out_tdata, prev_d);
                check("hold_tkeep", m_axis_out_tkeep, prev_k);
                check("hold_tlast", m_axis_out_tlast, prev_l);
            end
            if (m_axis_out_tvalid && m_axis_out_tready) begin
                out_cnt++;
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h, expected no output", m_axis_out_tdata);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("sb_tdata", m_axis_out_tdata, e.d);
                    check("sb_tkeep", m_axis_out_tkeep, e.k);
                    check("sb_tlast", m_axis_out_tlast, e.l);
                end
            end
            prev_stall = m_axis_out_tvalid && !m_axis_out_tready;
            prev_d = m_axis_out_tdata;
            prev_k = m_axis_out_tkeep;
            prev_l = m_axis_out_tlast;
        end
    end

    task automatic send(input logic [IW-1:0] d, input logic l, input int gap);
        int n;
        if (gap > 0) begin
            results_TVALID = 1'b0;
            repeat (gap) begin @(posedge ap_clk); #1; end
        end
        results_TVALID = 1'b1;
        results_TDATA  = d;
        results_TLAST  = l;
        n = 0;
        forever begin
            bit hs;
            @(negedge ap_clk);
            hs = results_TREADY;
            @(posedge ap_clk); #1;
            if (hs) break;
            n++;
            if (n > 2000) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: got no TREADY in %0d cycles, expected acceptance", n);
                break;
            end
        end
        results_TVALID = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        results_TVALID = 1'b0;
        cur.delete();
        expq.delete();
        exp_pkts = 0;
        in_acc = 0;
        out_cnt = 0;
        @(negedge ap_clk);
        check("rst_tready", results_TREADY, 0);
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        #1;
    endtask

    task automatic drain();
        int n;
        m_axis_out_tready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || m_axis_out_tvalid) && n < 2000) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check("drain_done", n < 2000, 1);
    endtask

    bit rdone;
    int nlast;
    logic [IW-1:0] base;

    initial begin
        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_tvalid", m_axis_out_tvalid, 0);
        check("rst_tdata", m_axis_out_tdata, 0);
        check("rst_tkeep", m_axis_out_tkeep, 0);
        check("rst_tlast", m_axis_out_tlast, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_tready_low", results_TREADY, 0);
        ap_rst_n = 1'b1;
        #1;
        check("post_rst_idle", idle, 1);
        check("post_rst_tready", results_TREADY, 1);

        // Full word with latency check
        base = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A0;
        for (int i = 0; i < 4; i++) send(base + IW'(i), i == 3, 0);
        check("full_latency_tvalid", m_axis_out_tvalid, 1);
        check("full_tdata", m_axis_out_tdata, {base + 128'd3, base + 128'd2, base + 128'd1, base});
        drain();
        check("full_pkt_count", pkt_count, 1);

        // Partial word
        do_reset();
        send(128'hB0, 1'b0, 0);
        send(128'hB1, 1'b1, 0);
        check("partial_tvalid", m_axis_out_tvalid, 1);
        check("partial_tkeep", m_axis_out_tkeep, 64'h0000_0000_FFFF_FFFF);
        check("partial_low", m_axis_out_tdata[255:0], {128'hB1, 128'hB0});
        check("partial_high", m_axis_out_tdata[511:256], 0);
        check("partial_tlast", m_axis_out_tlast, 1);
        drain();

        // Backpressure: 12 beats against a stalled output
        do_reset();
        m_axis_out_tready = 1'b0;
        fork
            for (int i = 0; i < 12; i++) send(128'hC00 + IW'(i), 1'b0, 0);
            begin
                repeat (20) begin @(posedge ap_clk); #1; end
                check("bp_accepted", in_acc, 8);
                check("bp_tready_low", results_TREADY, 0);
                check("bp_tvalid", m_axis_out_tvalid, 1);
                m_axis_out_tready = 1'b1;
            end
        join
        drain();
        check("bp_in_count", in_acc, 12);
        check("bp_out_count", out_cnt, 3);

        // Throughput
        do_reset();
        stall_cyc = 0;
        track_stall = 1;
        for (int i = 0; i < 400; i++) send({$urandom, $urandom, $urandom, $urandom}, (i % 8) == 7, 0);
        drain();
        track_stall = 0;
        check("tp_no_stall", stall_cyc, 0);
        check("tp_out_count", out_cnt, 100);
        check("tp_pkt_count", pkt_count, 50);

        // Reset mid-packet
        do_reset();
        for (int i = 0; i < 3; i++) send(128'hD0 + IW'(i), 1'b0, 0);
        do_reset();
        check("midrst_tvalid", m_axis_out_tvalid, 0);
        check("midrst_pkt_count", pkt_count, 0);
        check("midrst_idle", idle, 1);
        for (int i = 0; i < 4; i++) send(128'hE0 + IW'(i), i == 3, 0);
        check("midrst_lane0", m_axis_out_tdata[127:0], 128'hE0);
        drain();
        check("midrst_pkt_after", pkt_count, 1);

        // Random valid/ready
        do_reset();
        rdone = 0;
        nlast = 0;
        fork
            while (!rdone) begin
                @(posedge ap_clk); #1;
                m_axis_out_tready = ($urandom_range(1) == 1);
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic l;
                    l = (i == 999) || ($urandom_range(3) == 0);
                    if (l) nlast++;
                    send({$urandom, $urandom, $urandom, $urandom}, l,
                         ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0);
                end
                rdone = 1;
            end
        join
        drain();
        check("rand_in_count", in_acc, 1000);
        check("rand_queue_empty", expq.size(), 0);
        check("rand_pkt_count", pkt_count, nlast);
        check("rand_model_pkts", exp_pkts, nlast);
        check("rand_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by time limit, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
